shift_arbiter: RTL

- Shares one 32-bit combinational shifter (SLL/SRL/SRA) between two requesters: port 0 = pipeline EX stage, port 1 = auxiliary unit (e.g. CSR/debug or an iterative mul/div helper).
- Requests use a valid/ready handshake; arbitration is round-robin.
- The shifted result is registered once and returned with the winner's ID and tag on a valid/ready result channel.

---
 rtl/shift_pkg.sv | 31 +++
 rtl/shifter_32.sv | 34 +++
 rtl/shift_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the shared-shifter arbiter.
// The request struct carries the widest supported tag; users take the low TAG_W bits.
package shift_pkg;

  localparam int XLEN      = 32;
  localparam int SHAMT_W   = 5;
  localparam int TAG_MAX_W = 16;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_RSV = 2'b11
  } shift_op_e;

  typedef struct packed {
    shift_op_e              op;
    logic [XLEN-1:0]        a;
    logic [XLEN-1:0]        b;
    logic [TAG_MAX_W-1:0]   tag;
  } shift_req_t;

  function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = v[XLEN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shifter_32.sv
// Combinational 32-bit log shifter (16/8/4/2/1 stages) for SLL/SRL/SRA.
// Left shifts reuse the right-shift network by reversing the operand and the result.
module shifter_32
  import shift_pkg::*;
(
  input  shift_op_e          op,
  input  logic [XLEN-1:0]    a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [XLEN-1:0]    y
);

  logic            left;
  logic            fill;
  logic [XLEN-1:0] src;
  logic [XLEN-1:0] s16;
  logic [XLEN-1:0] s8;
  logic [XLEN-1:0] s4;
  logic [XLEN-1:0] s2;
  logic [XLEN-1:0] s1;

  // The reserved encoding falls through as a logical right shift.
  assign left = (op == SH_SLL);
  assign fill = (op == SH_SRA) & a[XLEN-1];
  assign src  = left ? bit_rev(a) : a;

  assign s16 = shamt[4] ? {{16{fill}}, src[XLEN-1:16]} : src;
  assign s8  = shamt[3] ? {{8{fill}},  s16[XLEN-1:8]}  : s16;
  assign s4  = shamt[2] ? {{4{fill}},  s8[XLEN-1:4]}   : s8;
  assign s2  = shamt[1] ? {{2{fill}},  s4[XLEN-1:2]}   : s4;
  assign s1  = shamt[0] ? {fill,       s2[XLEN-1:1]}   : s2;

  assign y = left ? bit_rev(s1) : s1;

endmodule

// File: rtl/shift_arbiter.sv
// Two-port arbiter sharing one shifter, with a single registered result slot.
// state | meaning: ST_EMPTY | result slot empty ; ST_FULL | slot holds a result (o_rsp_valid)
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter bit FAIR  = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [1:0]            i_req_valid,
  output logic [1:0]            o_req_ready,
  input  logic [1:0][1:0]       i_req_op,
  input  logic [1:0][XLEN-1:0]  i_req_a,
  input  logic [1:0][XLEN-1:0]  i_req_b,
  input  logic [1:0][TAG_W-1:0] i_req_tag,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [XLEN-1:0]       o_rsp_data,
  output logic                  o_rsp_id,
  output logic [TAG_W-1:0]      o_rsp_tag,
  output logic                  o_busy
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]      state;
  logic [0:0]      state_nxt;
  logic            rr_ptr;
  logic            slot_free;
  logic [1:0]      gnt;
  logic            win_id;
  shift_req_t      win_req;
  logic [XLEN-1:0] shift_y;
  logic            unused_bits;

  assign o_rsp_valid = (state == ST_FULL);
  assign slot_free   = !o_rsp_valid || i_rsp_ready;

  // Grant is held off during reset so nothing is accepted into a slot being cleared.
  always_comb begin
    gnt = 2'b00;
    if (i_rst_n && slot_free) begin
      unique case (i_req_valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (FAIR && rr_ptr) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign o_req_ready = gnt;
  assign win_id      = gnt[1];

  always_comb begin
    win_req                  = '0;
    win_req.op               = shift_op_e'(i_req_op[win_id]);
    win_req.a                = i_req_a[win_id];
    win_req.b                = i_req_b[win_id];
    win_req.tag[TAG_W-1:0]   = i_req_tag[win_id];
  end

  assign unused_bits = ^{win_req.b[XLEN-1:SHAMT_W], win_req.tag};

  shifter_32 u_shifter (
    .op    (win_req.op),
    .a     (win_req.a),
    .shamt (win_req.b[SHAMT_W-1:0]),
    .y     (shift_y)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_EMPTY: if (|gnt) state_nxt = ST_FULL;
      ST_FULL:  if (i_rsp_ready && !(|gnt)) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_EMPTY;
      rr_ptr     <= 1'b0;
      o_rsp_data <= '0;
      o_rsp_id   <= 1'b0;
      o_rsp_tag  <= '0;
    end else begin
      state <= state_nxt;
      if (|gnt) begin
        o_rsp_data <= shift_y;
        o_rsp_id   <= win_id;
        o_rsp_tag  <= win_req.tag[TAG_W-1:0];
        rr_ptr     <= ~win_id;
      end
    end
  end

  assign o_busy = o_rsp_valid || (|i_req_valid);

  // Requesters must hold valid and payload steady until accepted.
  for (genvar n = 0; n < 2; n++) begin : g_hold
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (i_req_valid[n] && !o_req_ready[n]) |=>
        (i_req_valid[n] && $stable(i_req_op[n]) && $stable(i_req_a[n]) &&
         $stable(i_req_b[n]) && $stable(i_req_tag[n])));
  end

  assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(o_req_ready));

endmodule
